// File: rtl/histogram_equalizer.sv
// Histogram equalizer for one square block of pixels.
// Each pixel is looked up in an external CDF RAM, rescaled to the full output
// range with a rounded restoring division, and written into the output block.
module histogram_equalizer #(
    parameter int IMAGE_WIDTH                 = 320,
    parameter int IMAGE_HEIGHT                = 240,
    parameter int PIXEL_WIDTH                 = 8,
    parameter int TABLE_SIZE                  = 64,
    parameter int HISTOGRAM_RAM_ADDRESS_WIDTH = PIXEL_WIDTH,
    parameter int HISTOGRAM_RAM_DATA_WIDTH    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [TABLE_SIZE*PIXEL_WIDTH-1:0]      image_table,
    input  logic                                   start_equalize,
    input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    CDF_min,
    input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    histogram_RAM_data,
    output logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] histogram_RAM_address,
    output logic                                   histogram_RAM_CE,
    output logic                                   histogram_RAM_WE,
    output logic [TABLE_SIZE*PIXEL_WIDTH-1:0]      equalized_table,
    output logic                                   busy,
    output logic                                   equalization_done
);

    // Arithmetic width: CDF word times (L-1) plus a rounding term, one spare bit.
    localparam int DW = HISTOGRAM_RAM_DATA_WIDTH + PIXEL_WIDTH + 1;
    localparam int IW = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
    localparam int CW = $clog2(PIXEL_WIDTH + 1);

    localparam logic [DW-1:0] N_PIXELS = DW'(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam logic [DW-1:0] L_MAX    = DW'((1 << PIXEL_WIDTH) - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(TABLE_SIZE - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(PIXEL_WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_DIVIDE = 2'd2;
    localparam logic [1:0] S_WRITE  = 2'd3;

    // How the result of the current pixel is formed once the divider finishes.
    localparam logic [1:0] M_DIV  = 2'd0;
    localparam logic [1:0] M_ZERO = 2'd1;
    localparam logic [1:0] M_PASS = 2'd2;
    localparam logic [1:0] M_SAT  = 2'd3;

    logic [1:0]                      r_state;
    logic [IW-1:0]                   r_index;
    logic                            r_done;
    logic [PIXEL_WIDTH-1:0]          r_pixel;
    logic [1:0]                      r_mode;
    logic [DW-1:0]                   r_remainder;
    logic [DW-1:0]                   r_divisor;
    logic [PIXEL_WIDTH-1:0]          r_quotient;
    logic [CW-1:0]                   r_count;
    logic [TABLE_SIZE*PIXEL_WIDTH-1:0] r_table;

    logic [PIXEL_WIDTH-1:0] w_pixel;
    logic [DW-1:0]          w_cdf;
    logic [DW-1:0]          w_min;
    logic [DW-1:0]          w_den;
    logic [DW-1:0]          w_diff;
    logic [DW-1:0]          w_num;
    logic [DW-1:0]          w_den_top;
    logic [1:0]             w_mode;
    logic                   w_fit;
    logic [PIXEL_WIDTH-1:0] w_result;

    assign w_pixel = image_table[int'(r_index)*PIXEL_WIDTH +: PIXEL_WIDTH];

    // Operand preparation for the pixel being read; evaluated during READ only.
    always_comb begin
        w_cdf     = DW'(histogram_RAM_data);
        w_min     = DW'(CDF_min);
        w_den     = (w_min >= N_PIXELS) ? '0 : (N_PIXELS - w_min);
        w_diff    = w_cdf - w_min;
        w_num     = (w_diff * L_MAX) + (w_den >> 1);
        w_den_top = w_den << PIXEL_WIDTH;
        w_mode    = M_DIV;
        if (w_den == '0) begin
            w_mode = M_PASS;
        end else if (w_cdf < w_min) begin
            w_mode = M_ZERO;
        end else if (w_num >= w_den_top) begin
            w_mode = M_SAT;
        end
    end

    assign w_fit = (r_remainder >= r_divisor);

    // Final pixel value, chosen by the case detected when the CDF was read.
    always_comb begin
        w_result = r_quotient;
        case (r_mode)
            M_ZERO:  w_result = '0;
            M_PASS:  w_result = r_pixel;
            M_SAT:   w_result = '1;
            default: w_result = r_quotient;
        endcase
    end

    // Sequencer and restoring divider: READ, PIXEL_WIDTH DIVIDE steps, WRITE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_done      <= 1'b0;
            r_pixel     <= '0;
            r_mode      <= M_DIV;
            r_remainder <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_count     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_equalize) begin
                        r_state <= S_READ;
                        r_index <= '0;
                    end
                end
                S_READ: begin
                    r_pixel     <= w_pixel;
                    r_mode      <= w_mode;
                    r_remainder <= w_num;
                    r_divisor   <= w_den << (PIXEL_WIDTH - 1);
                    r_quotient  <= '0;
                    r_count     <= '0;
                    r_state     <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    if (w_fit) begin
                        r_remainder <= r_remainder - r_divisor;
                        r_quotient  <= {r_quotient[PIXEL_WIDTH-2:0], 1'b1};
                    end else begin
                        r_quotient  <= {r_quotient[PIXEL_WIDTH-2:0], 1'b0};
                    end
                    r_divisor <= r_divisor >> 1;
                    if (r_count == LAST_BIT) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_index == LAST_IDX) begin
                        r_index <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_index <= r_index + 1'b1;
                        r_state <= S_READ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output block storage, updated one pixel per WRITE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_table <= '0;
        end else if (r_state == S_WRITE) begin
            r_table[int'(r_index)*PIXEL_WIDTH +: PIXEL_WIDTH] <= w_result;
        end
    end

    assign histogram_RAM_address = (r_state == S_READ) ? HISTOGRAM_RAM_ADDRESS_WIDTH'(w_pixel) : '0;
    assign histogram_RAM_CE      = (r_state == S_READ);
    assign histogram_RAM_WE      = 1'b0;
    assign equalized_table       = r_table;
    assign busy                  = (r_state != S_IDLE);
    assign equalization_done     = r_done;

endmodule

// File: tb/tb_histogram_equalizer.sv
// Scoreboard bench for histogram_equalizer: stimulus pushes expected blocks,
// a monitor pops and compares them on every equalization_done pulse.
module tb_histogram_equalizer;

    localparam int TS         = 64;
    localparam int PW         = 8;
    localparam int DW         = 17;
    localparam int AW         = 8;
    localparam int TW         = TS * PW;
    localparam int RUN_CYCLES = TS * (PW + 2);

    typedef struct {
        logic [TW-1:0] tbl;
        int            doneCycle;
    } expT;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [TW-1:0] imageTable = '0;
    logic          start = 1'b0;
    logic [DW-1:0] cdfMin = '0;
    logic [DW-1:0] ramData;
    logic [AW-1:0] ramAddr;
    logic          ramCE;
    logic          ramWE;
    logic [TW-1:0] eqTable;
    logic          busy;
    logic          done;
    logic [2:0]    ramMode = 3'd0;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  ceCnt = 0;
    int  busyCnt = 0;
    bit  weSeen = 1'b0;
    expT expQ[$];

    histogram_equalizer dut (
        .clk                   (clk),
        .rst                   (rst),
        .image_table           (imageTable),
        .start_equalize        (start),
        .CDF_min               (cdfMin),
        .histogram_RAM_data    (ramData),
        .histogram_RAM_address (ramAddr),
        .histogram_RAM_CE      (ramCE),
        .histogram_RAM_WE      (ramWE),
        .equalized_table       (eqTable),
        .busy                  (busy),
        .equalization_done     (done)
    );

    always #5 clk = ~clk;

    // CDF RAM model, selectable contents per test.
    always_comb begin
        ramData = '0;
        if (ramCE) begin
            case (ramMode)
                3'd0:    ramData = DW'((int'(ramAddr) + 1) * 300);
                3'd1:    ramData = DW'(100);
                3'd3:    ramData = (ramAddr < 8'd128) ? DW'(300) : DW'(76800);
                3'd4:    ramData = '1;
                default: ramData = '0;
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [TW-1:0] makeRamp(input bit rev);
        logic [TW-1:0] t;
        t = '0;
        for (int i = 0; i < TS; i++) begin
            t[i*PW +: PW] = rev ? PW'(255 - 4*i) : PW'(4*i);
        end
        if (!rev) begin
            t[1*PW +: PW] = 8'd127;
            t[2*PW +: PW] = 8'd255;
        end
        return t;
    endfunction

    function automatic logic [TW-1:0] fillTable(input logic [PW-1:0] v);
        logic [TW-1:0] t;
        t = '0;
        for (int i = 0; i < TS; i++) t[i*PW +: PW] = v;
        return t;
    endfunction

    function automatic logic [TW-1:0] thresholdOf(input logic [TW-1:0] src);
        logic [TW-1:0] t;
        t = '0;
        for (int i = 0; i < TS; i++) t[i*PW +: PW] = (src[i*PW +: PW] < 8'd128) ? 8'h00 : 8'hFF;
        return t;
    endfunction

    task automatic checkVal(input string name, input logic [TW-1:0] act, input logic [TW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic checkOutput(input expT e);
        checkVal("table", eqTable, e.tbl);
        checkVal("done_cycle", TW'(cyc), TW'(e.doneCycle));
        checkVal("busy_in_done", TW'(busy), TW'(0));
        checkVal("ce_count", TW'(ceCnt), TW'(TS));
        checkVal("busy_count", TW'(busyCnt), TW'(RUN_CYCLES));
        checkVal("we_seen", TW'(weSeen), TW'(0));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkVal({tag, "_busy"}, TW'(busy), TW'(0));
        checkVal({tag, "_done"}, TW'(done), TW'(0));
        checkVal({tag, "_ce"}, TW'(ramCE), TW'(0));
        checkVal({tag, "_we"}, TW'(ramWE), TW'(0));
        checkVal({tag, "_addr"}, TW'(ramAddr), TW'(0));
        checkVal({tag, "_table"}, eqTable, '0);
    endtask

    // Called just after a falling edge; start is seen at the next rising edge.
    task automatic applyStimulus(input logic [TW-1:0] tbl, input logic [DW-1:0] cmin,
                                 input logic [2:0] mode, input logic [TW-1:0] expTbl,
                                 input bit expectDone);
        expT e;
        imageTable = tbl;
        cdfMin     = cmin;
        ramMode    = mode;
        start      = 1'b1;
        if (expectDone) begin
            e.tbl       = expTbl;
            e.doneCycle = cyc + RUN_CYCLES + 1;
            expQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles);
        int n;
        n = 0;
        while (!done && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL done_timeout: got no pulse after %0d cycles, required one", n);
        end
    endtask

    // Monitor: per-run activity counters and scoreboard comparison on done.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                ceCnt   = 0;
                busyCnt = 0;
                weSeen  = 1'b0;
            end else begin
                if (ramCE) ceCnt++;
                if (busy) busyCnt++;
                if (ramWE) weSeen = 1'b1;
                if (done) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done: got pulse at cycle %0d, required none", cyc);
                    end else begin
                        checkOutput(expQ.pop_front());
                    end
                    ceCnt   = 0;
                    busyCnt = 0;
                    weSeen  = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [TW-1:0] ramp;
        logic [TW-1:0] rampRev;
        ramp    = makeRamp(1'b0);
        rampRev = makeRamp(1'b1);

        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] run A: identity CDF with a stray start mid-run");
        applyStimulus(ramp, DW'(300), 3'd0, ramp, 1'b1);
        repeat (198) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(RUN_CYCLES + 20);
        @(negedge clk);

        $display("[TB] run B: single-valued image, zero denominator");
        applyStimulus(fillTable(8'd42), DW'(76800), 3'd0, fillTable(8'd42), 1'b1);
        waitDone(RUN_CYCLES + 20);
        @(negedge clk);

        $display("[TB] run C: cdf below CDF_min");
        applyStimulus(ramp, DW'(300), 3'd1, '0, 1'b1);
        waitDone(RUN_CYCLES + 20);
        @(negedge clk);

        $display("[TB] run D: step CDF, then run E started in the done cycle");
        applyStimulus(ramp, DW'(300), 3'd3, thresholdOf(ramp), 1'b1);
        waitDone(RUN_CYCLES + 20);
        applyStimulus(ramp, DW'(300), 3'd4, fillTable(8'hFF), 1'b1);
        waitDone(RUN_CYCLES + 20);
        @(negedge clk);

        $display("[TB] run F: aborted by reset");
        applyStimulus(ramp, DW'(300), 3'd0, ramp, 1'b0);
        repeat (298) @(negedge clk);
        rst = 1'b0;
        #1;
        checkIdleOutputs("abort");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] run G: full run after abort");
        applyStimulus(rampRev, DW'(300), 3'd0, rampRev, 1'b1);
        waitDone(RUN_CYCLES + 20);
        repeat (5) @(negedge clk);

        checkVal("queue_empty", TW'(expQ.size()), TW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/histogram_equalizer.md
HISTOGRAM_EQUALIZER -- requirements
Module: histogram_equalizer

Interface
REQ-001 Parameter IMAGE_WIDTH, default 320, image width in pixels.
REQ-002 Parameter IMAGE_HEIGHT, default 240, image height in pixels.
REQ-003 Parameter PIXEL_WIDTH, default 8, bits per pixel.
REQ-004 Parameter TABLE_SIZE, default 64, pixels per square block (edge E = sqrt(TABLE_SIZE) = 8).
REQ-005 Parameter HISTOGRAM_RAM_ADDRESS_WIDTH, default PIXEL_WIDTH, CDF RAM address width.
REQ-006 Parameter HISTOGRAM_RAM_DATA_WIDTH, default clog2(IMAGE_WIDTH*IMAGE_HEIGHT) = 17, CDF word width.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 rst  input  1  reset, asynchronous assertion, active-low.
REQ-009 image_table  input  TABLE_SIZE*PIXEL_WIDTH  source block; pixel i at bits [i*PIXEL_WIDTH +: PIXEL_WIDTH]; held stable while busy.
REQ-010 start_equalize  input  1  one-cycle start request.
REQ-011 CDF_min  input  HISTOGRAM_RAM_DATA_WIDTH  first non-zero CDF value; held stable while busy.
REQ-012 histogram_RAM_data  input  HISTOGRAM_RAM_DATA_WIDTH  CDF RAM read data, combinational w.r.t. address and CE.
REQ-013 histogram_RAM_address  output  HISTOGRAM_RAM_ADDRESS_WIDTH  CDF RAM address.
REQ-014 histogram_RAM_CE  output  1  RAM chip enable.
REQ-015 histogram_RAM_WE  output  1  RAM write enable; tied 0, this block never writes the RAM or drives the shared data bus.
REQ-016 equalized_table  output  TABLE_SIZE*PIXEL_WIDTH  equalized block, same packing as image_table.
REQ-017 busy  output  1  high from the cycle after an accepted start until done.
REQ-018 equalization_done  output  1  one-cycle pulse; equalized_table complete.

Function
REQ-019 States: IDLE, READ, DIVIDE, WRITE; reset state IDLE.
REQ-020 IDLE: start_equalize=1 -> READ with pixel index 0; start ignored in any other state.
REQ-021 Pixel order: index = w + h*E, w fastest, 0..TABLE_SIZE-1.
REQ-022 READ (1 cycle): address = image_table pixel[index], CE=1; latch cdf = histogram_RAM_data; -> DIVIDE.
REQ-023 CE=1 only in READ; address = 0 outside READ.
REQ-024 Arithmetic: L = 2^PIXEL_WIDTH; N = IMAGE_WIDTH*IMAGE_HEIGHT; den = N - CDF_min; num = (cdf - CDF_min)*(L-1) + floor(den/2); result = floor(num/den); intermediates sized to avoid overflow (>= HISTOGRAM_RAM_DATA_WIDTH+PIXEL_WIDTH+1 bits).
REQ-025 DIVIDE: restoring divider, one quotient bit per cycle MSB first, exactly PIXEL_WIDTH cycles; result saturates at L-1.
REQ-026 cdf < CDF_min -> result 0; den = 0 -> result = original pixel; cycle count unchanged in both cases.
REQ-027 WRITE (1 cycle): equalized_table pixel[index] <= result; index = TABLE_SIZE-1 -> IDLE, index to 0, equalization_done=1 next cycle; else index+1, -> READ.
REQ-028 Per-pixel cost PIXEL_WIDTH+2 cycles; start accepted at edge k -> equalization_done high for the cycle after edge k+TABLE_SIZE*(PIXEL_WIDTH+2) (640 cycles default), busy low in that same cycle.
REQ-029 equalized_table holds last result until overwritten pixel-by-pixel by the next run.
REQ-030 start_equalize in the cycle equalization_done is high is accepted (state is IDLE).

Reset
REQ-031 rst low: immediately state IDLE, index 0, busy 0, equalization_done 0, CE 0, WE 0, address 0, equalized_table all 0, divider registers 0.
REQ-032 Reset mid-run aborts without a done pulse; the next start restarts from index 0.

Verification
REQ-033 RAM model cdf[v]=(v+1)*300, CDF_min=300, table pixels 0,127,255 -> equalized 0,127,255.
REQ-034 CDF_min=76800 (single-valued image), table all 42 -> equalized all 42, done after 640 cycles.
REQ-035 cdf[pixel]=100, CDF_min=300 -> equalized 0.
REQ-036 Any run: WE never 1, CE high exactly 64 cycles, done exactly one pulse at cycle k+641, busy high 640 cycles.
REQ-037 start pulsed at cycle 200 of a run -> ignored, single done at 640.
REQ-038 rst low at cycle 300 -> all outputs 0 immediately, no done; new start -> full correct run.
